// File: rtl/uart_pkg.sv
// Shared constants for the UART transmit arbiter: FSM encodings and widths.
package uart_pkg;

  localparam int unsigned UART_BYTE_W        = 8;
  localparam int unsigned UART_DEF_MAX_BURST = 16;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_ISSUE = 3'd1;
  localparam logic [2:0] ST_WBUSY = 3'd2;
  localparam logic [2:0] ST_WRDY  = 3'd3;
  localparam logic [2:0] ST_HOLD  = 3'd4;

endpackage

// File: rtl/uart_rr_pick.sv
// Combinational round-robin picker: nearest requester after last_owner wins.
module uart_rr_pick #(
  parameter int P_NREQ = 4,
  parameter int P_IW   = 2
) (
  input  logic [P_NREQ-1:0] req,
  input  logic [P_IW-1:0]   last_owner,
  output logic [P_NREQ-1:0] pick_oh,
  output logic [P_IW-1:0]   pick_idx,
  output logic              pick_vld
);

  logic [P_IW-1:0] idx;

  // Scan from farthest to nearest so the nearest hit overwrites earlier ones.
  always_comb begin
    pick_oh  = '0;
    pick_idx = '0;
    pick_vld = 1'b0;
    idx      = '0;
    for (int k = P_NREQ; k >= 1; k--) begin
      idx = P_IW'((int'(last_owner) + k) % P_NREQ);
      if (req[idx]) begin
        pick_oh      = '0;
        pick_oh[idx] = 1'b1;
        pick_idx     = idx;
        pick_vld     = 1'b1;
      end
    end
  end

endmodule

// File: rtl/uart_tx_arb.sv
// Round-robin arbiter feeding one UART transmitter, with packet locking and burst cap.
// Optional CTS flow control enabled by defining UART_TX_ARB_CTS_EN.
module uart_tx_arb
  import uart_pkg::*;
#(
  parameter int P_NREQ      = 4,
  parameter int P_MAX_BURST = UART_DEF_MAX_BURST
) (
  input  logic                          FPGA_CLK,
  input  logic                          FPGA_RST_N,
  input  logic [P_NREQ-1:0]             IREQ_DVLD,
  input  logic [UART_BYTE_W*P_NREQ-1:0] IREQ_DT,
  input  logic [P_NREQ-1:0]             IREQ_LAST,
  output logic [P_NREQ-1:0]             OREQ_ACK,
  output logic                          OTX_DVLD,
  output logic [UART_BYTE_W-1:0]        OTX_DT,
  input  logic                          ITX_READY,
  input  logic                          ICTS,
  input  logic                          ICTS_EN,
  output logic [P_NREQ-1:0]             OGNT,
  output logic                          OBUSY
);

  localparam int IW = (P_NREQ > 1) ? $clog2(P_NREQ) : 1;
  localparam logic [IW-1:0] LAST_RST  = IW'(P_NREQ - 1);
  localparam logic [7:0]    MAX_BURST = 8'(P_MAX_BURST);

  logic [2:0]             state_q, state_d;
  logic [P_NREQ-1:0]      gnt_q, gnt_d;
  logic [IW-1:0]          owner_q, owner_d;
  logic [IW-1:0]          last_owner_q, last_owner_d;
  logic [7:0]             burst_q, burst_d;
  logic                   tx_dvld_q, tx_dvld_d;
  logic [UART_BYTE_W-1:0] tx_dt_q, tx_dt_d;
  logic [P_NREQ-1:0]      ack_q, ack_d;
  logic                   pkt_last_q, pkt_last_d;

  logic [P_NREQ-1:0]      pick_oh;
  logic [IW-1:0]          pick_idx;
  logic                   pick_vld;
  logic                   fc_ok;
  logic                   issue_ok;
  logic                   issue;
  logic                   owner_vld;
  logic [IW-1:0]          sel_idx;
  logic [UART_BYTE_W-1:0] sel_dat;
  logic                   sel_last;

`ifdef UART_TX_ARB_CTS_EN
  // CTS only gates the start of a byte; a byte already issued always completes.
  assign fc_ok = !ICTS_EN || !ICTS;
`else
  logic unused_cts;
  assign unused_cts = ICTS ^ ICTS_EN;
  assign fc_ok      = 1'b1;
`endif

  assign issue_ok  = ITX_READY && fc_ok;
  assign owner_vld = |(IREQ_DVLD & gnt_q);

  uart_rr_pick #(
    .P_NREQ (P_NREQ),
    .P_IW   (IW)
  ) u_pick (
    .req        (IREQ_DVLD),
    .last_owner (last_owner_q),
    .pick_oh    (pick_oh),
    .pick_idx   (pick_idx),
    .pick_vld   (pick_vld)
  );

  always_comb begin
    sel_idx  = (state_q == ST_IDLE) ? pick_idx : owner_q;
    sel_dat  = '0;
    sel_last = 1'b0;
    for (int i = 0; i < P_NREQ; i++) begin
      if (sel_idx == IW'(i)) begin
        sel_dat  = IREQ_DT[i*UART_BYTE_W +: UART_BYTE_W];
        sel_last = IREQ_LAST[i];
      end
    end
  end

  always_comb begin
    state_d      = state_q;
    gnt_d        = gnt_q;
    owner_d      = owner_q;
    last_owner_d = last_owner_q;
    burst_d      = burst_q;
    tx_dvld_d    = 1'b0;
    tx_dt_d      = tx_dt_q;
    ack_d        = '0;
    pkt_last_d   = pkt_last_q;
    issue        = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (issue_ok && pick_vld) begin
          issue   = 1'b1;
          gnt_d   = pick_oh;
          owner_d = pick_idx;
          burst_d = 8'd1;
          ack_d   = pick_oh;
        end
      end
      ST_ISSUE: state_d = ST_WBUSY;
      ST_WBUSY: begin
        if (!ITX_READY) state_d = ST_WRDY;
      end
      ST_WRDY: begin
        if (ITX_READY) begin
          if (pkt_last_q || (burst_q == MAX_BURST)) begin
            gnt_d        = '0;
            last_owner_d = owner_q;
            state_d      = ST_IDLE;
          end else begin
            state_d = ST_HOLD;
          end
        end
      end
      ST_HOLD: begin
        if (issue_ok && owner_vld) begin
          issue = 1'b1;
          ack_d = gnt_q;
          if (burst_q != 8'hFF) burst_d = burst_q + 8'd1;
        end
      end
      default: begin
        state_d = ST_IDLE;
        gnt_d   = '0;
      end
    endcase
    if (issue) begin
      state_d    = ST_ISSUE;
      tx_dvld_d  = 1'b1;
      tx_dt_d    = sel_dat;
      pkt_last_d = sel_last;
    end
  end

  always_ff @(posedge FPGA_CLK or negedge FPGA_RST_N) begin
    if (!FPGA_RST_N) begin
      state_q      <= ST_IDLE;
      gnt_q        <= '0;
      owner_q      <= '0;
      last_owner_q <= LAST_RST;
      burst_q      <= 8'd0;
      tx_dvld_q    <= 1'b0;
      tx_dt_q      <= '0;
      ack_q        <= '0;
      pkt_last_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      gnt_q        <= gnt_d;
      owner_q      <= owner_d;
      last_owner_q <= last_owner_d;
      burst_q      <= burst_d;
      tx_dvld_q    <= tx_dvld_d;
      tx_dt_q      <= tx_dt_d;
      ack_q        <= ack_d;
      pkt_last_q   <= pkt_last_d;
    end
  end

  assign OREQ_ACK = ack_q;
  assign OTX_DVLD = tx_dvld_q;
  assign OTX_DT   = tx_dt_q;
  assign OGNT     = gnt_q;
  assign OBUSY    = (state_q != ST_IDLE);

endmodule

// File: tb/tb_uart_tx_arb.sv
// Directed bench for uart_tx_arb; requesters and the UART transmitter are driven from tasks.
module tb_uart_tx_arb;

  localparam int NREQ = 4;

  logic              fpga_clk = 1'b0;
  logic              fpga_rst_n;
  logic [NREQ-1:0]   ireq_dvld;
  logic [8*NREQ-1:0] ireq_dt;
  logic [NREQ-1:0]   ireq_last;
  logic [NREQ-1:0]   oreq_ack;
  logic              otx_dvld;
  logic [7:0]        otx_dt;
  logic              itx_ready;
  logic              icts;
  logic              icts_en;
  logic [NREQ-1:0]   ognt;
  logic              obusy;

  int n_cmp = 0;
  int n_bad = 0;

  logic [7:0] r_dat [NREQ][8];
  logic       r_lst [NREQ][8];
  int         r_cnt [NREQ];
  int         r_pos [NREQ];
  int         lat;

  always #5 fpga_clk = ~fpga_clk;

  uart_tx_arb #(
    .P_NREQ      (NREQ),
    .P_MAX_BURST (4)
  ) dut (
    .FPGA_CLK   (fpga_clk),
    .FPGA_RST_N (fpga_rst_n),
    .IREQ_DVLD  (ireq_dvld),
    .IREQ_DT    (ireq_dt),
    .IREQ_LAST  (ireq_last),
    .OREQ_ACK   (oreq_ack),
    .OTX_DVLD   (otx_dvld),
    .OTX_DT     (otx_dt),
    .ITX_READY  (itx_ready),
    .ICTS       (icts),
    .ICTS_EN    (icts_en),
    .OGNT       (ognt),
    .OBUSY      (obusy)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic drive_reqs();
    for (int i = 0; i < NREQ; i++) begin
      if (r_pos[i] < r_cnt[i]) begin
        ireq_dvld[i]       = 1'b1;
        ireq_dt[i*8 +: 8]  = r_dat[i][r_pos[i]];
        ireq_last[i]       = r_lst[i][r_pos[i]];
      end else begin
        ireq_dvld[i]       = 1'b0;
        ireq_dt[i*8 +: 8]  = 8'h00;
        ireq_last[i]       = 1'b0;
      end
    end
  endtask

  task automatic clear_reqs();
    for (int i = 0; i < NREQ; i++) begin
      r_cnt[i] = 0;
      r_pos[i] = 0;
    end
    drive_reqs();
  endtask

  task automatic add_pkt(input int i, input int n, input logic [7:0] base, input bit last_end);
    for (int j = 0; j < n; j++) begin
      r_dat[i][r_cnt[i]] = base + 8'(j);
      r_lst[i][r_cnt[i]] = last_end && (j == n - 1);
      r_cnt[i]++;
    end
  endtask

  task automatic apply_reset();
    fpga_rst_n = 1'b0;
    itx_ready  = 1'b1;
    icts       = 1'b0;
    icts_en    = 1'b0;
    clear_reqs();
    repeat (2) @(negedge fpga_clk);
    fpga_rst_n = 1'b1;
  endtask

  task automatic wait_issue(output int n);
    n = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge fpga_clk);
      n++;
      if (otx_dvld) break;
    end
    if (!otx_dvld) chk("issue_timeout", 32'(otx_dvld), 32'd1);
  endtask

  // One byte from requester idx: check the issue cycle, then play the transmitter.
  task automatic serve(input int idx, input string tag, output int n);
    logic [7:0] exp_dat;
    exp_dat = r_dat[idx][r_pos[idx]];
    wait_issue(n);
    chk({tag, "_ack"}, 32'(oreq_ack), 32'(1 << idx));
    chk({tag, "_gnt"}, 32'(ognt), 32'(1 << idx));
    chk({tag, "_dat"}, 32'(otx_dt), 32'(exp_dat));
    for (int i = 0; i < NREQ; i++)
      if (oreq_ack[i] && r_pos[i] < r_cnt[i]) r_pos[i]++;
    drive_reqs();
    itx_ready = 1'b0;
    @(negedge fpga_clk);
    chk({tag, "_dvld_drop"}, 32'(otx_dvld), 32'd0);
    @(negedge fpga_clk);
    @(negedge fpga_clk);
    chk({tag, "_dat_hold"}, 32'(otx_dt), 32'(exp_dat));
    itx_ready = 1'b1;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    fpga_rst_n = 1'b0;
    itx_ready  = 1'b1;
    icts       = 1'b0;
    icts_en    = 1'b0;
    clear_reqs();
    #3;
    chk("rst_out", {26'd0, otx_dvld, obusy, ognt}, 32'd0);
    chk("rst_ack_dt", {20'd0, oreq_ack, otx_dt}, 32'd0);
    apply_reset();

    // Single byte, one-cycle latency, grant clears after ready returns
    add_pkt(0, 1, 8'hA5, 1'b1);
    drive_reqs();
    serve(0, "t1", lat);
    chk("t1_lat", 32'(lat), 32'd1);
    @(negedge fpga_clk);
    chk("t1_gnt_clr", 32'(ognt), 32'd0);
    chk("t1_idle", 32'(obusy), 32'd0);

    // All four valid, single-byte packets: 0,1,2,3,0,1,2,3
    apply_reset();
    for (int i = 0; i < NREQ; i++) begin
      add_pkt(i, 1, 8'(8'h10 * i), 1'b1);
      add_pkt(i, 1, 8'(8'h10 * i + 8), 1'b1);
    end
    drive_reqs();
    for (int k = 0; k < 8; k++) serve(k % 4, "rr", lat);

    // Packet lock: requester 2 sends three bytes before requester 0
    apply_reset();
    add_pkt(1, 1, 8'h40, 1'b1);
    drive_reqs();
    serve(1, "lk_pre", lat);
    add_pkt(2, 3, 8'h20, 1'b1);
    add_pkt(0, 1, 8'h0C, 1'b1);
    drive_reqs();
    serve(2, "lk_a", lat);
    serve(2, "lk_b", lat);
    serve(2, "lk_c", lat);
    serve(0, "lk_d", lat);

    // Burst cap of 4 forces rotation; owner then waits in hold indefinitely
    apply_reset();
    add_pkt(1, 6, 8'h50, 1'b0);
    add_pkt(3, 1, 8'h70, 1'b1);
    drive_reqs();
    for (int k = 0; k < 4; k++) serve(1, "bc1", lat);
    serve(3, "bc3", lat);
    serve(1, "bc1b", lat);
    serve(1, "bc1c", lat);
    repeat (6) @(negedge fpga_clk);
    chk("hold_busy", 32'(obusy), 32'd1);
    chk("hold_gnt", 32'(ognt), 32'b0010);
    chk("hold_nodvld", 32'(otx_dvld), 32'd0);

    // Transmitter not ready in idle: no grant, no ack
    apply_reset();
    itx_ready = 1'b0;
    add_pkt(0, 1, 8'h3C, 1'b1);
    drive_reqs();
    repeat (3) @(negedge fpga_clk);
    chk("nrdy_gnt", 32'(ognt), 32'd0);
    chk("nrdy_ack", 32'({oreq_ack, otx_dvld}), 32'd0);
    itx_ready = 1'b1;
    serve(0, "nrdy", lat);
    chk("nrdy_lat", 32'(lat), 32'd1);

    // CTS: blocks issue only when the flow-control option is built in
    apply_reset();
    icts_en = 1'b1;
    icts    = 1'b1;
    add_pkt(0, 1, 8'hC3, 1'b1);
    drive_reqs();
`ifdef UART_TX_ARB_CTS_EN
    repeat (3) @(negedge fpga_clk);
    chk("cts_block", 32'(otx_dvld), 32'd0);
    icts = 1'b0;
`endif
    serve(0, "cts", lat);
    chk("cts_lat", 32'(lat), 32'd1);
    icts_en = 1'b0;

    // Reset while waiting for the transmitter to finish
    apply_reset();
    add_pkt(2, 1, 8'h99, 1'b1);
    drive_reqs();
    wait_issue(lat);
    chk("mr_gnt", 32'(ognt), 32'b0100);
    itx_ready = 1'b0;
    @(negedge fpga_clk);
    @(negedge fpga_clk);
    chk("mr_busy", 32'(obusy), 32'd1);
    #2 fpga_rst_n = 1'b0;
    #1;
    chk("mr_out", {18'd0, otx_dt, otx_dvld, obusy, ognt}, 32'd0);
    chk("mr_ack", 32'(oreq_ack), 32'd0);
    @(negedge fpga_clk);
    fpga_rst_n = 1'b1;
    itx_ready  = 1'b1;
    clear_reqs();
    for (int i = 0; i < NREQ; i++) add_pkt(i, 1, 8'(8'hE0 + i), 1'b1);
    drive_reqs();
    serve(0, "mr_first", lat);
    serve(1, "mr_second", lat);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
